// File: rtl/axi_lite_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi_lite_pkg
// Description : Shared widths, response codes, channel payload structs and
//               FSM state encodings for the AXI4-Lite RAM responder.
//               No ports (package).
// Revision    : 1.0 - initial release
// ============================================================================
package axi_lite_pkg;

    localparam int ADDR_WIDTH = 12;
    localparam int DATA_WIDTH = 8;
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    typedef logic [ADDR_WIDTH-1:0] addr_t;
    typedef logic [DATA_WIDTH-1:0] data_t;
    typedef logic [STRB_WIDTH-1:0] strb_t;
    typedef logic [1:0]            resp_t;

    localparam resp_t RESP_OKAY   = 2'b00;
    localparam resp_t RESP_SLVERR = 2'b10;

    // Channel payloads, for benches/monitors that want to bundle signals.
    typedef struct packed {
        addr_t addr;
    } aw_chan_t;

    typedef struct packed {
        data_t data;
        strb_t strb;
    } w_chan_t;

    typedef struct packed {
        resp_t resp;
    } b_chan_t;

    typedef struct packed {
        addr_t addr;
    } ar_chan_t;

    typedef struct packed {
        data_t data;
        resp_t resp;
    } r_chan_t;

    typedef enum logic [1:0] {
        W_IDLE      = 2'd0,
        W_WAIT_DATA = 2'd1,
        W_WAIT_ADDR = 2'd2,
        W_RESP      = 2'd3
    } wr_state_t;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_t;

endpackage : axi_lite_pkg
`default_nettype wire

// File: rtl/axi_lite_ram_bank.sv
`default_nettype none
// ============================================================================
// Module      : axi_lite_ram_bank
// Description : Simple dual-port storage array: one byte-enabled write port
//               and one registered read port. A read and a write to the same
//               word on the same edge returns the pre-write contents.
//               Storage is never reset.
// Ports       : clk      - clock
//               wr_en    - write enable
//               wr_addr  - write word index
//               wr_data  - write data
//               wr_strb  - per-byte write enables
//               rd_en    - read enable (updates rd_data on the next edge)
//               rd_addr  - read word index
//               rd_data  - registered read data, held until next rd_en
// Revision    : 1.0 - initial release
// ============================================================================
module axi_lite_ram_bank #(
    parameter int DATA_WIDTH     = 8,
    parameter int MEM_DEPTH      = 256,
    parameter int RAM_ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
    input  logic                      clk,
    input  logic                      wr_en,
    input  logic [RAM_ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0]     wr_data,
    input  logic [DATA_WIDTH/8-1:0]   wr_strb,
    input  logic                      rd_en,
    input  logic [RAM_ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0]     rd_data
);
    import axi_lite_pkg::*;

    localparam int c_lanes = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];
    logic [DATA_WIDTH-1:0] r_rd_data;

    // Non-blocking write and read in the same process give read-before-write
    // on a same-index collision.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < c_lanes; i++) begin
                if (wr_strb[i]) begin
                    r_mem[wr_addr][i*8 +: 8] <= wr_data[i*8 +: 8];
                end
            end
        end
        if (rd_en) begin
            r_rd_data <= r_mem[rd_addr];
        end
    end

    assign rd_data = r_rd_data;

endmodule : axi_lite_ram_bank
`default_nettype wire

// File: rtl/axi_lite_slave_ram.sv
`default_nettype none
// ============================================================================
// Module      : axi_lite_slave_ram
// Description : AXI4-Lite responder backed by a byte-strobed RAM bank.
//               Independent write (AW/W/B) and read (AR/R) FSMs share one
//               storage array. Word index = addr >> log2(STRB_WIDTH); indices
//               at or beyond MEM_DEPTH answer SLVERR with no side effects.
// Ports       : clk, rst                      - clock, sync active-high reset
//               awaddr/awvalid/awready        - write address channel
//               wdata/wstrb/wvalid/wready     - write data channel
//               bresp/bvalid/bready           - write response channel
//               araddr/arvalid/arready        - read address channel
//               rdata/rresp/rvalid/rready     - read data channel
// Revision    : 1.0 - initial release
// ============================================================================
module axi_lite_slave_ram #(
    parameter int ADDR_WIDTH = axi_lite_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = axi_lite_pkg::DATA_WIDTH,
    parameter int MEM_DEPTH  = 256
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wvalid,
    output logic                    wready,
    output logic [1:0]              bresp,
    output logic                    bvalid,
    input  logic                    bready,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    input  logic                    arvalid,
    output logic                    arready,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic                    rvalid,
    input  logic                    rready
);
    import axi_lite_pkg::*;

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int c_offs     = $clog2(STRB_WIDTH);
    localparam int c_ram_aw   = $clog2(MEM_DEPTH);

    // ------------------------------------------------------------------
    // Address decode helpers
    // ------------------------------------------------------------------
    function automatic logic f_in_range(input logic [ADDR_WIDTH-1:0] a);
        return 32'(a >> c_offs) < 32'(MEM_DEPTH);
    endfunction

    function automatic logic [c_ram_aw-1:0] f_ram_idx(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH-1:0] t;
        t = a >> c_offs;
        return t[c_ram_aw-1:0];
    endfunction

    // ------------------------------------------------------------------
    // Write path
    // ------------------------------------------------------------------
    wr_state_t               r_wr_state;
    wr_state_t               w_wr_next;
    logic                    r_awready;
    logic                    r_wready;
    logic [1:0]              r_bresp;
    logic [ADDR_WIDTH-1:0]   r_aw_addr;
    logic [DATA_WIDTH-1:0]   r_w_data;
    logic [STRB_WIDTH-1:0]   r_w_strb;

    logic                    w_aw_hs;
    logic                    w_w_hs;
    logic                    w_commit;
    logic                    w_lat_aw;
    logic                    w_lat_w;
    logic [ADDR_WIDTH-1:0]   w_cm_addr;
    logic [DATA_WIDTH-1:0]   w_cm_data;
    logic [STRB_WIDTH-1:0]   w_cm_strb;
    logic                    w_ram_we;

    assign w_aw_hs = awvalid & r_awready;
    assign w_w_hs  = wvalid & r_wready;

    always_comb begin
        w_wr_next = r_wr_state;
        w_commit  = 1'b0;
        w_lat_aw  = 1'b0;
        w_lat_w   = 1'b0;
        w_cm_addr = r_aw_addr;
        w_cm_data = r_w_data;
        w_cm_strb = r_w_strb;
        case (r_wr_state)
            W_IDLE: begin
                if (w_aw_hs && w_w_hs) begin
                    w_commit  = 1'b1;
                    w_cm_addr = awaddr;
                    w_cm_data = wdata;
                    w_cm_strb = wstrb;
                    w_wr_next = W_RESP;
                end else if (w_aw_hs) begin
                    w_lat_aw  = 1'b1;
                    w_wr_next = W_WAIT_DATA;
                end else if (w_w_hs) begin
                    w_lat_w   = 1'b1;
                    w_wr_next = W_WAIT_ADDR;
                end
            end
            W_WAIT_DATA: begin
                if (w_w_hs) begin
                    w_commit  = 1'b1;
                    w_cm_data = wdata;
                    w_cm_strb = wstrb;
                    w_wr_next = W_RESP;
                end
            end
            W_WAIT_ADDR: begin
                if (w_aw_hs) begin
                    w_commit  = 1'b1;
                    w_cm_addr = awaddr;
                    w_wr_next = W_RESP;
                end
            end
            W_RESP: begin
                if (bready) begin
                    w_wr_next = W_IDLE;
                end
            end
            default: w_wr_next = W_IDLE;
        endcase
    end

    // Readies are registered from the next state so they stay low through
    // reset and come up on the first edge after it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_state <= W_IDLE;
            r_awready  <= 1'b0;
            r_wready   <= 1'b0;
            r_bresp    <= RESP_OKAY;
        end else begin
            r_wr_state <= w_wr_next;
            r_awready  <= (w_wr_next == W_IDLE) || (w_wr_next == W_WAIT_ADDR);
            r_wready   <= (w_wr_next == W_IDLE) || (w_wr_next == W_WAIT_DATA);
            if (w_commit) begin
                r_bresp <= f_in_range(w_cm_addr) ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    // Half-transaction holding registers; contents only matter in the
    // matching wait state, so no reset.
    always_ff @(posedge clk) begin
        if (w_lat_aw) begin
            r_aw_addr <= awaddr;
        end
        if (w_lat_w) begin
            r_w_data <= wdata;
            r_w_strb <= wstrb;
        end
    end

    // A commit that lands on a reset edge must not reach the array.
    assign w_ram_we = w_commit & f_in_range(w_cm_addr) & ~rst;

    assign awready = r_awready;
    assign wready  = r_wready;
    assign bvalid  = (r_wr_state == W_RESP);
    assign bresp   = r_bresp;

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    rd_state_t               r_rd_state;
    rd_state_t               w_rd_next;
    logic                    r_arready;
    logic [1:0]              r_rresp;
    logic                    w_rd_accept;
    logic                    w_ram_re;
    logic [DATA_WIDTH-1:0]   w_ram_rdata;

    always_comb begin
        w_rd_next   = r_rd_state;
        w_rd_accept = 1'b0;
        case (r_rd_state)
            R_IDLE: begin
                if (arvalid && r_arready) begin
                    w_rd_accept = 1'b1;
                    w_rd_next   = R_DATA;
                end
            end
            R_DATA: begin
                if (rready) begin
                    w_rd_next = R_IDLE;
                end
            end
            default: w_rd_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_state <= R_IDLE;
            r_arready  <= 1'b0;
            r_rresp    <= RESP_OKAY;
        end else begin
            r_rd_state <= w_rd_next;
            r_arready  <= (w_rd_next == R_IDLE);
            if (w_rd_accept) begin
                r_rresp <= f_in_range(araddr) ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    assign w_ram_re = w_rd_accept & f_in_range(araddr);

    assign arready = r_arready;
    assign rvalid  = (r_rd_state == R_DATA);
    assign rresp   = r_rresp;
    // The array's read register is not reset and is not loaded on SLVERR,
    // so rdata is forced to zero unless an OKAY beat is being presented.
    assign rdata   = ((r_rd_state == R_DATA) && (r_rresp == RESP_OKAY)) ? w_ram_rdata : '0;

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    axi_lite_ram_bank #(
        .DATA_WIDTH     (DATA_WIDTH),
        .MEM_DEPTH      (MEM_DEPTH),
        .RAM_ADDR_WIDTH (c_ram_aw)
    ) u_ram (
        .clk     (clk),
        .wr_en   (w_ram_we),
        .wr_addr (f_ram_idx(w_cm_addr)),
        .wr_data (w_cm_data),
        .wr_strb (w_cm_strb),
        .rd_en   (w_ram_re),
        .rd_addr (f_ram_idx(araddr)),
        .rd_data (w_ram_rdata)
    );

endmodule : axi_lite_slave_ram
`default_nettype wire

// File: tb/tb_axi_lite_slave_ram.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_lite_slave_ram
// Description : Directed self-checking bench for axi_lite_slave_ram. Expected
//               responses are queued when a request is driven and compared
//               when the DUT presents the matching B or R beat.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_lite_slave_ram;

    localparam logic [1:0] c_okay   = 2'b00;
    localparam logic [1:0] c_slverr = 2'b10;

    logic        clk;
    logic        rst;
    logic [11:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [7:0]  wdata;
    logic [0:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [11:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [7:0]  rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    int n_checks = 0;
    int n_pass   = 0;

    logic [1:0] b_q[$];
    logic [9:0] r_q[$];
    logic [7:0] model [256];

    axi_lite_slave_ram dut (
        .clk     (clk),
        .rst     (rst),
        .awaddr  (awaddr),
        .awvalid (awvalid),
        .awready (awready),
        .wdata   (wdata),
        .wstrb   (wstrb),
        .wvalid  (wvalid),
        .wready  (wready),
        .bresp   (bresp),
        .bvalid  (bvalid),
        .bready  (bready),
        .araddr  (araddr),
        .arvalid (arvalid),
        .arready (arready),
        .rdata   (rdata),
        .rresp   (rresp),
        .rvalid  (rvalid),
        .rready  (rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish before 200us");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [1:0] exp_resp(input logic [11:0] a);
        return (a < 12'h100) ? c_okay : c_slverr;
    endfunction

    function automatic logic [9:0] exp_read(input logic [11:0] a);
        if (a < 12'h100) return {c_okay, model[a[7:0]]};
        return {c_slverr, 8'h00};
    endfunction

    task automatic model_write(input logic [11:0] a, input logic [7:0] d, input logic s);
        if ((a < 12'h100) && s) model[a[7:0]] = d;
    endtask

    // Consume the B beat that appears one cycle after the commit edge, then
    // hold bready low for 'hold' cycles before accepting it.
    task automatic finish_b(input string tag, input int hold);
        logic [1:0] e;
        @(negedge clk);
        e = b_q.pop_front();
        check({tag, "_bvalid"}, {31'd0, bvalid}, 32'd1);
        check({tag, "_bresp"}, {30'd0, bresp}, {30'd0, e});
        for (int i = 0; i < hold; i++) begin
            if (i > 0) @(negedge clk);
            check({tag, "_bhold"}, {28'd0, bvalid, bresp, awready, wready}, {28'd0, 1'b1, e, 2'b00});
        end
        bready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic write_both(input logic [11:0] a, input logic [7:0] d, input logic s, input int hold);
        check("aw_w_ready", {30'd0, awready, wready}, 32'd3);
        awaddr = a; awvalid = 1'b1; wdata = d; wstrb = s; wvalid = 1'b1;
        bready = (hold == 0);
        b_q.push_back(exp_resp(a));
        model_write(a, d, s);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        finish_b("wr", hold);
    endtask

    task automatic write_w_first(input logic [11:0] a, input logic [7:0] d, input int gap);
        wdata = d; wstrb = 1'b1; wvalid = 1'b1; bready = 1'b1;
        @(posedge clk); #1;
        wvalid = 1'b0;
        for (int i = 0; i < gap; i++) begin
            @(negedge clk);
            check("wfirst_wait", {29'd0, awready, wready, bvalid}, 32'b100);
            if (i == gap - 1) begin
                awaddr = a; awvalid = 1'b1;
                b_q.push_back(exp_resp(a));
                model_write(a, d, 1'b1);
            end
        end
        @(posedge clk); #1;
        awvalid = 1'b0;
        finish_b("wfirst", 0);
    endtask

    task automatic write_aw_first(input logic [11:0] a, input logic [7:0] d, input int gap);
        awaddr = a; awvalid = 1'b1; bready = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0;
        for (int i = 0; i < gap; i++) begin
            @(negedge clk);
            check("awfirst_wait", {29'd0, awready, wready, bvalid}, 32'b010);
        end
        wdata = d; wstrb = 1'b1; wvalid = 1'b1;
        b_q.push_back(exp_resp(a));
        model_write(a, d, 1'b1);
        @(posedge clk); #1;
        wvalid = 1'b0;
        finish_b("awfirst", 0);
    endtask

    task automatic read(input logic [11:0] a, input int hold);
        logic [9:0] e;
        check("ar_ready", {31'd0, arready}, 32'd1);
        araddr = a; arvalid = 1'b1; rready = (hold == 0);
        r_q.push_back(exp_read(a));
        @(posedge clk); #1;
        arvalid = 1'b0;
        @(negedge clk);
        e = r_q.pop_front();
        check("rd_rvalid", {31'd0, rvalid}, 32'd1);
        check("rd_data", {22'd0, rresp, rdata}, {22'd0, e});
        for (int i = 0; i < hold; i++) begin
            if (i > 0) @(negedge clk);
            check("rd_hold", {20'd0, rvalid, rresp, rdata, arready}, {20'd0, 1'b1, e, 1'b0});
        end
        rready = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [1:0] be;
        logic [9:0] re;
        rst = 1'b1;
        awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
        bready = 1'b0; araddr = '0; arvalid = 1'b0; rready = 1'b0;

        // 1. Reset with random inputs
        for (int i = 0; i < 3; i++) begin
            awaddr = 12'($urandom); awvalid = 1'($urandom); wdata = 8'($urandom);
            wstrb = 1'($urandom); wvalid = 1'($urandom); bready = 1'($urandom);
            araddr = 12'($urandom); arvalid = 1'($urandom); rready = 1'($urandom);
            @(posedge clk);
            @(negedge clk);
            check("reset_outputs", {awready, wready, bvalid, bresp, arready, rvalid, rresp, rdata},
                  32'd0);
        end
        rst = 1'b0;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; bready = 1'b1; rready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("post_reset", {27'd0, awready, wready, arready, bvalid, rvalid}, 32'b11100);

        // 2. Simultaneous AW/W write then readback
        write_both(12'h004, 8'hA5, 1'b1, 0);
        read(12'h004, 0);

        // 3. W leads AW by three cycles; AW leads W by two
        write_w_first(12'h014, 8'h3C, 3);
        read(12'h014, 0);
        write_aw_first(12'h020, 8'h5E, 2);
        read(12'h020, 0);

        // 4. Backpressure on B and R, then normal traffic resumes
        write_both(12'h024, 8'hC3, 1'b1, 5);
        read(12'h004, 4);
        write_both(12'h028, 8'h81, 1'b1, 0);
        read(12'h028, 0);
        read(12'h024, 0);

        // 5. Out-of-range (no aliasing onto word 0) and zero strobe
        write_both(12'h000, 8'h11, 1'b1, 0);
        write_both(12'h100, 8'hFF, 1'b1, 0);
        read(12'h100, 0);
        read(12'hFFF, 0);
        read(12'h000, 0);
        write_both(12'h004, 8'h00, 1'b0, 0);
        read(12'h004, 0);

        // 6a. AR handshake on the same edge as a commit to the same word
        awaddr = 12'h004; awvalid = 1'b1; wdata = 8'h77; wstrb = 1'b1; wvalid = 1'b1;
        araddr = 12'h004; arvalid = 1'b1; bready = 1'b1; rready = 1'b1;
        r_q.push_back(exp_read(12'h004));
        b_q.push_back(exp_resp(12'h004));
        model_write(12'h004, 8'h77, 1'b1);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        @(negedge clk);
        be = b_q.pop_front();
        re = r_q.pop_front();
        check("coll_b", {29'd0, bvalid, bresp}, {29'd0, 1'b1, be});
        check("coll_r", {21'd0, rvalid, rresp, rdata}, {21'd0, 1'b1, re});
        @(posedge clk); #1;
        read(12'h004, 0);

        // 6b. Reset while waiting for write data
        write_both(12'h030, 8'h5A, 1'b1, 0);
        awaddr = 12'h030; awvalid = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0;
        @(negedge clk);
        check("wait_data_ready", {30'd0, awready, wready}, 32'b01);
        rst = 1'b1;
        wdata = 8'h99; wstrb = 1'b1; wvalid = 1'b1;
        @(posedge clk); #1;
        wvalid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("mid_reset_ready", {27'd0, awready, wready, arready, bvalid, rvalid}, 32'b11100);
        read(12'h030, 0);
        read(12'h004, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_axi_lite_slave_ram
`default_nettype wire
